// File: rtl/audio_fetch_scheduler.sv
// audio_fetch_scheduler: per-frame sample fetch scheduler for CHANNEL_COUNT audio channels.
//   clk, rst (async, active-low)      : clock and reset
//   lrclk                             : raw I2S LR clock; each rising edge starts one frame
//   cfg_*                             : one-cycle descriptor write for channel cfg_ch
//   mem_req/mem_addr/mem_ack/mem_data : sample-word read handshake
//   smp_valid/smp_ch/smp_data         : fetched 16-bit sample, one-cycle pulse
//   ch_active, ch_end                 : per-channel active flags and end-of-sample pulses
//   frame_done, overrun               : frame complete pulse; lrclk edge dropped while busy
module audio_fetch_scheduler #(
    parameter int CHANNEL_COUNT = 8,
    localparam int CH_W = CHANNEL_COUNT > 1 ? $clog2(CHANNEL_COUNT) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lrclk,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [11:0]              cfg_start_addr,
    input  logic [23:0]              cfg_sample_count,
    input  logic [23:0]              cfg_loop_start,
    input  logic [23:0]              cfg_loop_end,
    input  logic                     cfg_looping,
    input  logic                     cfg_play,
    output logic                     mem_req,
    output logic [23:0]              mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_data,
    output logic                     smp_valid,
    output logic [CH_W-1:0]          smp_ch,
    output logic [15:0]              smp_data,
    output logic [CHANNEL_COUNT-1:0] ch_active,
    output logic [CHANNEL_COUNT-1:0] ch_end,
    output logic                     frame_done,
    output logic                     overrun
);
    typedef enum logic [2:0] {IDLE, SCAN, REQ, ADVANCE, DONE} state_t;
    state_t state, state_n;
    logic [CH_W-1:0] ch_idx, ch_idx_n;
    logic [11:0] start_addr [CHANNEL_COUNT];
    logic [23:0] sample_count [CHANNEL_COUNT];
    logic [23:0] loop_start [CHANNEL_COUNT];
    logic [23:0] loop_end [CHANNEL_COUNT];
    logic [23:0] position [CHANNEL_COUNT];
    logic [CHANNEL_COUNT-1:0] looping, active;
    logic sync1, sync2, sync3, lr_rise;
    logic [23:0] addr_q;
    logic half_q;
    logic [15:0] sample_q;
    logic last_ch, cfg_hit, loop_wrap, ends, advance;
    logic [23:0] next_pos;

    assign lr_rise   = sync2 & ~sync3;
    assign last_ch   = ch_idx == CH_W'(CHANNEL_COUNT - 1);
    // A config write to the channel being advanced overrides the position update.
    assign cfg_hit   = cfg_we && cfg_ch == ch_idx;
    assign next_pos  = position[ch_idx] + 24'd1;
    assign loop_wrap = looping[ch_idx] && next_pos == loop_end[ch_idx];
    assign ends      = !loop_wrap && next_pos >= sample_count[ch_idx];
    assign advance   = state == ADVANCE && !cfg_hit;

    assign mem_req    = state == REQ;
    assign mem_addr   = mem_req ? addr_q : 24'd0;
    assign smp_valid  = state == ADVANCE;
    assign smp_ch     = smp_valid ? ch_idx : '0;
    assign smp_data   = smp_valid ? sample_q : 16'd0;
    assign ch_end     = advance && ends ? CHANNEL_COUNT'(1) << ch_idx : '0;
    assign frame_done = state == DONE;
    assign overrun    = lr_rise && state != IDLE;
    assign ch_active  = active;

    always_comb begin
        state_n  = state;
        ch_idx_n = ch_idx;
        case (state)
            IDLE: begin
                state_n  = lr_rise ? SCAN : IDLE;
                ch_idx_n = lr_rise ? '0 : ch_idx;
            end
            SCAN: begin
                state_n  = active[ch_idx] ? REQ : last_ch ? DONE : SCAN;
                ch_idx_n = active[ch_idx] || last_ch ? ch_idx : ch_idx + 1'b1;
            end
            REQ:     state_n = mem_ack ? ADVANCE : REQ;
            ADVANCE: begin
                state_n  = last_ch ? DONE : SCAN;
                ch_idx_n = last_ch ? ch_idx : ch_idx + 1'b1;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ch_idx <= '0;
        end else begin
            state  <= state_n;
            ch_idx <= ch_idx_n;
        end
    end

    // Address and half-word select are latched on entry to REQ so that a config
    // write during the fetch cannot disturb the outstanding request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {sync1, sync2, sync3} <= 3'b000;
            addr_q   <= 24'd0;
            half_q   <= 1'b0;
            sample_q <= 16'd0;
        end else begin
            {sync1, sync2, sync3} <= {lrclk, sync1, sync2};
            if (state == SCAN && active[ch_idx]) begin
                addr_q <= {start_addr[ch_idx], 12'h000} + {1'b0, position[ch_idx][23:1]};
                half_q <= position[ch_idx][0];
            end
            if (state == REQ && mem_ack)
                sample_q <= half_q ? mem_data[31:16] : mem_data[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                start_addr[i]   <= 12'd0;
                sample_count[i] <= 24'd0;
                loop_start[i]   <= 24'd0;
                loop_end[i]     <= 24'd0;
                position[i]     <= 24'd0;
            end
            looping <= '0;
            active  <= '0;
        end else begin
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                if (cfg_we && cfg_ch == CH_W'(i)) begin
                    start_addr[i]   <= cfg_start_addr;
                    sample_count[i] <= cfg_sample_count;
                    loop_start[i]   <= cfg_loop_start;
                    loop_end[i]     <= cfg_loop_end;
                    looping[i]      <= cfg_looping;
                    position[i]     <= 24'd0;
                    active[i]       <= cfg_play;
                end else if (advance && ch_idx == CH_W'(i)) begin
                    position[i] <= loop_wrap ? loop_start[i] : ends ? 24'd0 : next_pos;
                    if (ends)
                        active[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_audio_fetch_scheduler.sv
// tb_audio_fetch_scheduler: self-checking bench for audio_fetch_scheduler (8 channels).
//   Drives lrclk frames, answers memory requests with random latency and data, and
//   checks addresses, samples, end pulses and frame status against a channel model.
module tb_audio_fetch_scheduler;
    logic clk = 0, rst = 0, lrclk = 0, cfg_we = 0;
    logic [2:0] cfg_ch = 0;
    logic [11:0] cfg_start_addr = 0;
    logic [23:0] cfg_sample_count = 0, cfg_loop_start = 0, cfg_loop_end = 0;
    logic cfg_looping = 0, cfg_play = 0, mem_ack = 0;
    logic [31:0] mem_data = 0;
    logic mem_req, smp_valid, frame_done, overrun;
    logic [23:0] mem_addr;
    logic [2:0] smp_ch;
    logic [15:0] smp_data;
    logic [7:0] ch_active, ch_end;

    audio_fetch_scheduler #(.CHANNEL_COUNT(8)) dut (
        .clk(clk), .rst(rst), .lrclk(lrclk),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_start_addr(cfg_start_addr),
        .cfg_sample_count(cfg_sample_count), .cfg_loop_start(cfg_loop_start),
        .cfg_loop_end(cfg_loop_end), .cfg_looping(cfg_looping), .cfg_play(cfg_play),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .smp_valid(smp_valid), .smp_ch(smp_ch), .smp_data(smp_data),
        .ch_active(ch_active), .ch_end(ch_end), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch; logic [11:0] sa; logic [23:0] cnt, ls, le; bit lp; int skip;
        logic [31:0] data; logic [23:0] eaddr; logic [15:0] edata; bit eend;
    } vec_t;

    logic [11:0] m_start [8];
    logic [23:0] m_cnt [8], m_ls [8], m_le [8], m_pos [8];
    bit m_lp [8], m_act [8];
    int n_chk = 0, n_fail = 0;
    logic [23:0] last_addr;
    logic [15:0] last_data;
    bit last_end, fdata_en = 0;
    logic [31:0] fdata;
    int frame_cycles, n_valid, n_req;
    logic [11:0] inj_sa;
    logic [23:0] inj_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic void load_model(int c, logic [11:0] sa, logic [23:0] cnt, ls, le, bit lp, bit play);
        m_start[c] = sa; m_cnt[c] = cnt; m_ls[c] = ls; m_le[c] = le; m_lp[c] = lp;
        m_pos[c] = 0; m_act[c] = play;
    endfunction

    // Word address = start page * 4096 + sample index / 2, wrapped to 24 bits.
    function automatic logic [23:0] exp_addr(int c);
        return 24'((int'(m_start[c]) * 4096 + int'(m_pos[c] / 2)) % (1 << 24));
    endfunction

    function automatic bit model_step(int c);
        logic [23:0] nx = m_pos[c] + 1;
        if (m_lp[c] && nx == m_le[c]) m_pos[c] = m_ls[c];
        else if (nx >= m_cnt[c]) begin
            m_pos[c] = 0; m_act[c] = 0;
            return 1;
        end else m_pos[c] = nx;
        return 0;
    endfunction

    function automatic logic [7:0] act_vec();
        logic [7:0] v;
        for (int c = 0; c < 8; c++) v[c] = m_act[c];
        return v;
    endfunction

    task automatic cfg(input int c, input logic [11:0] sa, input logic [23:0] cnt, ls, le, input bit lp, play);
        cfg_we = 1; cfg_ch = 3'(c); cfg_start_addr = sa; cfg_sample_count = cnt;
        cfg_loop_start = ls; cfg_loop_end = le; cfg_looping = lp; cfg_play = play;
        @(negedge clk);
        cfg_we = 0;
        load_model(c, sa, cnt, ls, le, lp, play);
    endtask

    task automatic clear_all();
        for (int c = 0; c < 8; c++) cfg(c, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_cfg(input int c);
        cfg(c, 12'($urandom), 24'($urandom_range(7, 0)), 24'($urandom_range(3, 0)),
            24'($urandom_range(6, 1)), 1'($urandom), $urandom_range(4, 0) != 0);
    endtask

    // One frame: raise lrclk, serve requests, check every output each cycle.
    task automatic run_frame(input int dmin, input int dmax, input bit extra, input int inj);
        int q[$];
        int k = 0, dly = 0, ovr = 0, c;
        bit busy = 0, acked = 0, done = 0, e;
        logic [31:0] d = 0;
        logic [23:0] held = 0;
        for (int i = 0; i < 8; i++) if (m_act[i]) q.push_back(i);
        last_end = 0; n_valid = 0; n_req = 0; frame_cycles = -1;
        lrclk = 1;
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
            cfg_we = 0;
            if (overrun) ovr++;
            if (frame_done) begin
                done = 1; frame_cycles = k - 1;
                chk("frame_all_serviced", q.size(), 0);
            end
            if (mem_req) begin
                n_req++;
                if (q.size() == 0) chk("mem_req_unexpected", {31'b0, mem_req}, 0);
                else if (!busy) begin
                    held = exp_addr(q[0]);
                    chk("mem_addr", mem_addr, held);
                    last_addr = mem_addr; busy = 1; dly = $urandom_range(dmax, dmin);
                end else chk("mem_addr_stable", mem_addr, held);
            end
            if (smp_valid) begin
                n_valid++;
                if (q.size() == 0 || !acked) chk("smp_valid_unexpected", {31'b0, smp_valid}, 0);
                else begin
                    c = q.pop_front();
                    chk("smp_ch", smp_ch, c);
                    chk("smp_data", smp_data, m_pos[c][0] ? d[31:16] : d[15:0]);
                    last_data = smp_data;
                    e = model_step(c);
                    if (c == inj) begin
                        cfg_we = 1; cfg_ch = 3'(c); cfg_start_addr = inj_sa; cfg_sample_count = inj_cnt;
                        cfg_loop_start = 0; cfg_loop_end = 0; cfg_looping = 0; cfg_play = 1;
                        load_model(c, inj_sa, inj_cnt, 0, 0, 0, 1);
                        #1 chk("ch_end_suppressed", ch_end, 0);
                    end else chk("ch_end", ch_end, e ? 8'(1) << c : 8'd0);
                    last_end |= ch_end[c];
                    busy = 0; acked = 0;
                end
            end else chk("ch_end_idle", ch_end, 0);
            if (k == 3) lrclk = 0;
            if (extra && k == 12) lrclk = 1;
            if (extra && k == 16) lrclk = 0;
            if (mem_req && busy && !acked) begin
                if (dly == 0) begin
                    d = fdata_en ? fdata : $urandom;
                    mem_data = d; mem_ack = 1; acked = 1;
                end else begin
                    dly--; mem_ack = 0;
                end
            end else begin
                mem_ack = $urandom_range(3, 0) == 0; mem_data = $urandom;
            end
        end
        if (!done) chk("frame_done_timeout", {31'b0, frame_done}, 1);
        chk("overrun_count", ovr, extra);
        mem_ack = 0; lrclk = 0; cfg_we = 0;
        repeat (3) begin
            @(negedge clk);
            chk("quiet_after_frame", {frame_done, mem_req, smp_valid, overrun}, 0);
        end
        chk("ch_active", ch_active, act_vec());
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [7];
        logic [23:0] ea [6];
        int w, tot;
        tbl[0] = '{2, 12'h001, 24'd4, 24'd0, 24'd0, 1'b0, 0, 32'hBBBBAAAA, 24'h001000, 16'hAAAA, 1'b0};
        tbl[1] = '{2, 12'h001, 24'd4, 24'd0, 24'd0, 1'b0, 1, 32'hBBBBAAAA, 24'h001000, 16'hBBBB, 1'b0};
        tbl[2] = '{5, 12'hFFF, 24'h100, 24'd0, 24'd0, 1'b0, 3, 32'h12345678, 24'hFFF001, 16'h1234, 1'b0};
        tbl[3] = '{0, 12'h000, 24'd3, 24'd0, 24'd0, 1'b0, 2, 32'hCAFEF00D, 24'h000001, 16'hF00D, 1'b1};
        tbl[4] = '{7, 12'h123, 24'd0, 24'd0, 24'd0, 1'b0, 0, 32'h0000BEEF, 24'h123000, 16'hBEEF, 1'b1};
        tbl[5] = '{1, 12'h0AB, 24'd100, 24'd2, 24'd5, 1'b1, 4, 32'h11112222, 24'h0AB002, 16'h2222, 1'b0};
        tbl[6] = '{3, 12'h800, 24'h800000, 24'd0, 24'd0, 1'b0, 1, 32'h99998888, 24'h800000, 16'h9999, 1'b0};
        ea = '{24'h002000, 24'h002000, 24'h002001, 24'h002001, 24'h002002, 24'h002001};
        for (int c = 0; c < 8; c++) load_model(c, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("reset_outputs", {mem_req, smp_valid, frame_done, overrun}, 0);
        chk("reset_ch_active", ch_active, 0);
        chk("reset_mem_addr", mem_addr, 0);
        rst = 1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            clear_all();
            fdata_en = 1; fdata = tbl[i].data;
            cfg(tbl[i].ch, tbl[i].sa, tbl[i].cnt, tbl[i].ls, tbl[i].le, tbl[i].lp, 1);
            repeat (tbl[i].skip + 1) run_frame(0, 2, 0, -1);
            chk($sformatf("vec%0d_addr", i), last_addr, tbl[i].eaddr);
            chk($sformatf("vec%0d_data", i), last_data, tbl[i].edata);
            chk($sformatf("vec%0d_end", i), last_end, tbl[i].eend);
            fdata_en = 0;
        end

        clear_all();
        cfg(0, 12'h000, 24'd3, 0, 0, 0, 1);
        repeat (3) run_frame(0, 2, 0, -1);
        chk("ch0_end_third_frame", last_end, 1);
        chk("ch0_inactive", ch_active[0], 0);
        run_frame(0, 2, 0, -1);
        chk("empty_frame_no_req", n_req, 0);
        chk("empty_frame_latency", frame_cycles, 10);

        clear_all();
        cfg(1, 12'h002, 24'd100, 24'd2, 24'd5, 1, 1);
        tot = 0;
        for (int f = 0; f < 6; f++) begin
            run_frame(0, 2, 0, -1);
            chk($sformatf("loop_addr_f%0d", f), last_addr, ea[f]);
            tot += int'(last_end);
        end
        chk("loop_never_ends", tot, 0);

        clear_all();
        for (int c = 0; c < 8; c++) cfg(c, 12'(c * 16), 24'd50, 0, 0, 0, 1);
        run_frame(3, 3, 1, -1);
        chk("all_ch_valid_count", n_valid, 8);

        clear_all();
        cfg(3, 12'h030, 24'd8, 0, 0, 0, 1);
        repeat (7) run_frame(0, 1, 0, -1);
        inj_sa = 12'h030; inj_cnt = 24'd8;
        run_frame(0, 1, 0, 3);
        chk("ch3_still_active", ch_active[3], 1);
        run_frame(0, 1, 0, -1);
        chk("ch3_restart_addr", last_addr, 24'h030000);

        clear_all();
        for (int c = 0; c < 8; c++) rand_cfg(c);
        repeat (20) begin
            if ($urandom_range(3, 0) == 0) rand_cfg($urandom_range(7, 0));
            run_frame(0, 3, 0, -1);
        end

        clear_all();
        cfg(0, 12'h010, 24'd10, 0, 0, 0, 1);
        lrclk = 1; w = 0;
        while (!mem_req && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("req_before_reset", mem_req, 1);
        rst = 0;
        #1;
        chk("reset_drops_req", mem_req, 0);
        chk("reset_clears_active", ch_active, 0);
        lrclk = 0; mem_ack = 1; mem_data = $urandom;
        repeat (2) @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        chk("late_ack_ignored", {mem_req, smp_valid}, 0);
        mem_ack = 0;
        for (int c = 0; c < 8; c++) load_model(c, 0, 0, 0, 0, 0, 0);
        repeat (2) begin
            run_frame(0, 0, 0, -1);
            chk("post_reset_no_req", n_req, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
